axi_r_stream_tap: RTL and testbench
===================================

Name: axi_r_stream_tap

Overview:
- Pass-through tap on an AXI read-data (R) channel with parametrised widths, capture depth and metadata mode.
- Forwards R beats from the downstream AXI master side to the upstream AXI slave side unchanged.
- Each accepted beat is queued, then serialised onto a single stream output as a data word followed by a metadata word.
- Sits between interconnect and processor read port and feeds the Ethernet packetiser stream arbiter.

Parameters:
- DATA_WIDTH, 128: R data width; also stream word width. Must be >= ID_WIDTH+19.
- ID_WIDTH, 32: RID width.
- USER_WIDTH, 64: RUSER width; passed through only.
- FIFO_DEPTH, 4: captured beats held; power of two, >= 2.
- META_MODE, 0: 0 = metadata word after every beat; 1 = metadata word only after beats with rlast=1.
- STREAM_TYPE, 3'b0: constant placed on m_ttype.
- STREAM_TYPE_WIDTH, 3: width of m_ttype.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- can_forward  in  1  arbiter permission; 0 stalls the R channel.
- AXIM_rid/rdata/rresp/rlast/ruser/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH/1  R beat from downstream.
- AXIM_rready  out  1  ready to downstream.
- AXIS_rid/rdata/rresp/rlast/ruser/rvalid  out  same widths  R beat to upstream; payload is a combinational copy of AXIM_*.
- AXIS_rready  in  1  ready from upstream.
- m_tvalid  out  1  stream word valid.
- m_tready  in  1  stream consumer ready.
- m_tdata  out  DATA_WIDTH  stream word.
- m_tkind  out  1  0 = data word, 1 = metadata word.
- m_tlast  out  1  last word of this beat's packet.
- m_ttype  out  STREAM_TYPE_WIDTH  equals STREAM_TYPE.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  queued beats.

Behaviour:
- Gate: en = can_forward && !full && !reset.
  - AXIS_rvalid = AXIM_rvalid && en.
  - AXIM_rready = AXIS_rready && en.
  - Transfer (xfer) = AXIM_rvalid && AXIS_rready && en. Zero-latency combinational pass-through.
- On xfer, push {rdata, rid, rresp, rlast, beat_idx} into the FIFO.
- full = (level == FIFO_DEPTH). Full blocks the channel even if a pop occurs in the same cycle; there is no same-cycle refill at full.
- Push and pop in the same cycle when not full: level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Serialiser FSM, all outputs registered:
  - IDLE: if level>0, load the head data word; m_tvalid=1, m_tkind=0; go to DATA.
  - DATA: hold the word until m_tready. On the handshake:
    - If a metadata word is required (META_MODE=0, or head rlast=1), load the meta word; m_tkind=1, m_tlast=1; go to META.
    - Otherwise pop the head. If the FIFO has more entries, load the next data word (remain DATA); else go to IDLE.
  - META: on m_tready, pop the head. If more entries remain, load the next data word and go to DATA; else go to IDLE.
- Data-word m_tlast is 0 whenever a metadata word follows. When META_MODE=1 and rlast=0, data-word m_tlast=0.
- m_tvalid is never deasserted without a handshake, and m_tdata is stable while stalled (AXIS rules).
- Metadata word layout:
  - [ID_WIDTH-1:0] = rid
  - [ID_WIDTH+1:ID_WIDTH] = rresp
  - [ID_WIDTH+2] = rlast
  - [ID_WIDTH+18:ID_WIDTH+3] = beat_idx (zero when the feature is disabled)
  - remaining bits 0
- Reset values: m_tvalid=0, m_tkind=0, m_tlast=0, m_tdata=0, level=0, pointers=0, FSM=IDLE, beat_idx=0.
- AXIS_rvalid and AXIM_rready are 0 while reset=1.
- Reset mid-operation discards queued beats and any stalled stream word. No partial packet is emitted after reset.

Optional Feature:
- Macro AXI_R_TAP_BEAT_COUNT_EN.
- Defined:
  - A 16-bit beat_idx counter increments on each xfer and clears to 0 on an xfer with rlast=1.
  - The value stored with each beat is the pre-increment count; the counter wraps at 65535.
  - The stored value appears in metadata bits [ID_WIDTH+18:ID_WIDTH+3].
- Undefined: no counter is built; those bits are constant 0.

Test Plan:
- Single beat, META_MODE=0, rid=0x5, rdata=0xA5A5, rresp=2, rlast=1, m_tready=1:
  - AXIS_rvalid is asserted in the same cycle.
  - Stream emits data 0xA5A5 (kind 0, tlast 0), then meta with rid=5, resp=2, last=1 (kind 1, tlast 1); level returns to 0.
- 4-beat burst, FIFO_DEPTH=4, m_tready=0:
  - All 4 accepted; level=4; AXIM_rready=0.
  - A 5th beat is held until m_tready=1 and the first meta handshake pops.
- META_MODE=1, 3-beat burst, rlast on beat 3, m_tready=1:
  - Stream words are D0, D1, D2, META (4 words); tlast only on META.
- can_forward=0 with AXIM_rvalid=1, AXIS_rready=1:
  - AXIS_rvalid=0, AXIM_rready=0, no push.
  - Release can_forward: transfer occurs in that cycle.
- Reset asserted for 1 cycle with level=2 and m_tvalid=1 during DATA:
  - Next cycle m_tvalid=0, level=0, FSM=IDLE.
  - A subsequent beat streams normally.
- With AXI_R_TAP_BEAT_COUNT_EN, two 4-beat bursts:
  - Meta beat_idx sequence is 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/axi_r_stream_tap.sv
// AXI R-channel pass-through tap: each accepted beat is queued and replayed as a data word plus optional metadata word.
// Optional: define AXI_R_TAP_BEAT_COUNT_EN to stamp each beat's index within its burst into the metadata word.
module axi_r_stream_tap #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH = 32,
  parameter int USER_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int META_MODE = 0,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              can_forward,
  input  logic [ID_WIDTH-1:0]               AXIM_rid,
  input  logic [DATA_WIDTH-1:0]             AXIM_rdata,
  input  logic [1:0]                        AXIM_rresp,
  input  logic                              AXIM_rlast,
  input  logic [USER_WIDTH-1:0]             AXIM_ruser,
  input  logic                              AXIM_rvalid,
  output logic                              AXIM_rready,
  output logic [ID_WIDTH-1:0]               AXIS_rid,
  output logic [DATA_WIDTH-1:0]             AXIS_rdata,
  output logic [1:0]                        AXIS_rresp,
  output logic                              AXIS_rlast,
  output logic [USER_WIDTH-1:0]             AXIS_ruser,
  output logic                              AXIS_rvalid,
  input  logic                              AXIS_rready,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tkind,
  output logic                              m_tlast,
  output logic [STREAM_TYPE_WIDTH-1:0]      m_ttype,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic                  last;
    logic [15:0]           idx;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_META} state_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head, nxt;
  logic [LW-1:0]   level;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            full, en, xfer, pop;
  logic [15:0]     cur_idx;
  state_t          state, state_nx;
  logic            tvalid_nx, tkind_nx, tlast_nx;
  logic [DATA_WIDTH-1:0] tdata_nx;

  // Gate uses the registered level, so a pop at full cannot free a slot for the same cycle.
  assign full = (level == LW'(FIFO_DEPTH));
  assign en   = can_forward && !full && !reset;
  assign xfer = AXIM_rvalid && AXIS_rready && en;

  assign AXIS_rvalid = AXIM_rvalid && en;
  assign AXIM_rready = AXIS_rready && en;
  assign AXIS_rid    = AXIM_rid;
  assign AXIS_rdata  = AXIM_rdata;
  assign AXIS_rresp  = AXIM_rresp;
  assign AXIS_rlast  = AXIM_rlast;
  assign AXIS_ruser  = AXIM_ruser;

  assign m_ttype    = STREAM_TYPE;
  assign fifo_level = level;

`ifdef AXI_R_TAP_BEAT_COUNT_EN
  logic [15:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (reset) beat_cnt <= '0;
    else if (xfer) beat_cnt <= AXIM_rlast ? 16'd0 : beat_cnt + 16'd1;
  end

  assign cur_idx = beat_cnt;
`else
  assign cur_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr] <= '{data: AXIM_rdata, id: AXIM_rid, resp: AXIM_rresp,
                               last: AXIM_rlast, idx: cur_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(xfer);
      rd_ptr <= rd_ptr + PW'(pop);
      level  <= level + LW'(xfer) - LW'(pop);
    end
  end

  assign head = mem[rd_ptr];
  assign nxt  = mem[rd_ptr + PW'(1)];

  function automatic logic [DATA_WIDTH-1:0] build_meta(input entry_t e);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[ID_WIDTH-1:0]      = e.id;
    w[ID_WIDTH +: 2]     = e.resp;
    w[ID_WIDTH+2]        = e.last;
    w[ID_WIDTH+3 +: 16]  = e.idx;
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      m_tvalid <= 1'b0;
      m_tkind  <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
    end else begin
      state    <= state_nx;
      m_tvalid <= tvalid_nx;
      m_tkind  <= tkind_nx;
      m_tlast  <= tlast_nx;
      m_tdata  <= tdata_nx;
    end
  end

  // "More entries" means beyond the current head; a beat pushed this cycle is picked up from IDLE.
  always_comb begin
    state_nx  = state;
    tvalid_nx = m_tvalid;
    tkind_nx  = m_tkind;
    tlast_nx  = m_tlast;
    tdata_nx  = m_tdata;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          tvalid_nx = 1'b1;
          tkind_nx  = 1'b0;
          tlast_nx  = 1'b0;
          tdata_nx  = head.data;
          state_nx  = S_DATA;
        end
      end
      S_DATA: begin
        if (m_tready) begin
          if (META_MODE == 0 || head.last) begin
            tdata_nx = build_meta(head);
            tkind_nx = 1'b1;
            tlast_nx = 1'b1;
            state_nx = S_META;
          end else begin
            pop = 1'b1;
            if (level > LW'(1)) begin
              tdata_nx = nxt.data;
              tkind_nx = 1'b0;
              tlast_nx = 1'b0;
            end else begin
              tvalid_nx = 1'b0;
              tkind_nx  = 1'b0;
              tlast_nx  = 1'b0;
              state_nx  = S_IDLE;
            end
          end
        end
      end
      S_META: begin
        if (m_tready) begin
          pop      = 1'b1;
          tkind_nx = 1'b0;
          tlast_nx = 1'b0;
          if (level > LW'(1)) begin
            tdata_nx = nxt.data;
            state_nx = S_DATA;
          end else begin
            tvalid_nx = 1'b0;
            state_nx  = S_IDLE;
          end
        end
      end
      default: begin
        tvalid_nx = 1'b0;
        state_nx  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_r_stream_tap.sv
// Randomized bench for axi_r_stream_tap: two lanes (metadata every beat / only after rlast) against a queue-based model.
module tb_axi_r_stream_tap;

  localparam int DW = 128;
  localparam int IW = 32;
  localparam int UW = 64;
  localparam int DEPTH = 4;
  localparam int NCYC = 4000;
`ifdef AXI_R_TAP_BEAT_COUNT_EN
  localparam bit BEAT_EN = 1'b1;
`else
  localparam bit BEAT_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] rid;
    logic [1:0]    resp;
    logic          last;
    logic [15:0]   idx;
  } beat_t;

  logic clk;
  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input int lane, input string tag, input logic [159:0] got,
                           input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL lane%0d %s: got %0h expected %0h (t=%0t)", lane, tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic reset, can_forward;
    logic [IW-1:0] AXIM_rid, AXIS_rid;
    logic [DW-1:0] AXIM_rdata, AXIS_rdata, m_tdata;
    logic [1:0]    AXIM_rresp, AXIS_rresp;
    logic          AXIM_rlast, AXIS_rlast, AXIM_rvalid, AXIM_rready, AXIS_rvalid, AXIS_rready;
    logic [UW-1:0] AXIM_ruser, AXIS_ruser;
    logic          m_tvalid, m_tready, m_tkind, m_tlast;
    logic [2:0]    m_ttype;
    logic [$clog2(DEPTH+1)-1:0] fifo_level;

    axi_r_stream_tap #(
      .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .FIFO_DEPTH(DEPTH),
      .META_MODE(g), .STREAM_TYPE_WIDTH(3), .STREAM_TYPE(3'(g + 5))
    ) u_dut (
      .clk(clk), .reset(reset), .can_forward(can_forward),
      .AXIM_rid(AXIM_rid), .AXIM_rdata(AXIM_rdata), .AXIM_rresp(AXIM_rresp),
      .AXIM_rlast(AXIM_rlast), .AXIM_ruser(AXIM_ruser), .AXIM_rvalid(AXIM_rvalid),
      .AXIM_rready(AXIM_rready),
      .AXIS_rid(AXIS_rid), .AXIS_rdata(AXIS_rdata), .AXIS_rresp(AXIS_rresp),
      .AXIS_rlast(AXIS_rlast), .AXIS_ruser(AXIS_ruser), .AXIS_rvalid(AXIS_rvalid),
      .AXIS_rready(AXIS_rready),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkind(m_tkind),
      .m_tlast(m_tlast), .m_ttype(m_ttype), .fifo_level(fifo_level)
    );

    beat_t q[$];

    initial begin
      int wi, gap, pr, pf, pv, pa;
      logic [15:0] idx_m;
      logic exp_en, xfer, hs, stalled, needs_meta;
      logic [DW-1:0] exp_word;
      beat_t b;

      reset = 1'b1; can_forward = 1'b0; AXIM_rvalid = 1'b0; AXIS_rready = 1'b0;
      m_tready = 1'b0; AXIM_rid = '0; AXIM_rdata = '0; AXIM_rresp = '0;
      AXIM_rlast = 1'b0; AXIM_ruser = '0;
      wi = 0; gap = 0; idx_m = '0; stalled = 1'b0;
      pr = 100; pf = 100; pv = 50; pa = 100;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val(g, "rst_tvalid", m_tvalid, 0);
      check_val(g, "rst_tdata", m_tdata, 0);
      check_val(g, "rst_tkind", m_tkind, 0);
      check_val(g, "rst_tlast", m_tlast, 0);
      check_val(g, "rst_level", fifo_level, 0);

      for (int c = 0; c < NCYC; c++) begin
        if (c % 40 == 0 && c > 0) begin
          case ($urandom_range(3))
            0: pr = 0;
            1: pr = 30;
            2: pr = 70;
            default: pr = 100;
          endcase
          pf = ($urandom_range(3) == 0) ? 20 : 100;
          pv = ($urandom_range(1) == 0) ? 30 : 90;
          pa = ($urandom_range(1) == 0) ? 50 : 100;
        end
        @(negedge clk);
        reset       = (c > 20) && ($urandom_range(199) == 0);
        can_forward = ($urandom_range(99) < pf);
        AXIM_rvalid = ($urandom_range(99) < pv);
        AXIS_rready = ($urandom_range(99) < pa);
        m_tready    = ($urandom_range(99) < pr);
        AXIM_rid    = $urandom;
        AXIM_rdata  = {$urandom, $urandom, $urandom, $urandom};
        AXIM_rresp  = 2'($urandom_range(3));
        AXIM_rlast  = ($urandom_range(3) == 0);
        AXIM_ruser  = {$urandom, $urandom};
        #1;

        exp_en = can_forward && (q.size() < DEPTH) && !reset;
        check_val(g, "axis_rvalid", AXIS_rvalid, AXIM_rvalid && exp_en);
        check_val(g, "axim_rready", AXIM_rready, AXIS_rready && exp_en);
        check_val(g, "level", fifo_level, q.size());
        check_val(g, "pass_rdata", AXIS_rdata, AXIM_rdata);
        check_val(g, "pass_rid", AXIS_rid, AXIM_rid);
        check_val(g, "pass_rresp", AXIS_rresp, AXIM_rresp);
        check_val(g, "pass_rlast", AXIS_rlast, AXIM_rlast);
        check_val(g, "pass_ruser", AXIS_ruser, AXIM_ruser);
        check_val(g, "ttype", m_ttype, g + 5);
        if (stalled) check_val(g, "tvalid_hold", m_tvalid, 1);

        if (q.size() == 0) begin
          check_val(g, "tvalid_idle", m_tvalid, 0);
          gap = 0;
        end else if (m_tvalid) begin
          b = q[0];
          if (wi == 0) exp_word = b.data;
          else exp_word = DW'({b.idx, b.last, b.resp, b.rid});
          check_val(g, "tdata", m_tdata, exp_word);
          check_val(g, "tkind", m_tkind, wi);
          check_val(g, "tlast", m_tlast, wi);
          gap = 0;
        end else begin
          gap++;
          if (gap > 2) check_val(g, "tvalid_latency", m_tvalid, 1);
        end

        hs      = m_tvalid && m_tready;
        stalled = m_tvalid && !m_tready && !reset;
        xfer    = AXIM_rvalid && AXIS_rready && exp_en;

        @(posedge clk);
        if (reset) begin
          q.delete();
          wi = 0;
          idx_m = '0;
        end else begin
          if (hs && q.size() > 0) begin
            needs_meta = (g == 0) || q[0].last;
            if (wi == 0 && needs_meta) wi = 1;
            else begin
              void'(q.pop_front());
              wi = 0;
            end
          end
          if (xfer) begin
            b.data = AXIM_rdata;
            b.rid  = AXIM_rid;
            b.resp = AXIM_rresp;
            b.last = AXIM_rlast;
            b.idx  = BEAT_EN ? idx_m : 16'd0;
            q.push_back(b);
            idx_m = AXIM_rlast ? 16'd0 : idx_m + 16'd1;
          end
        end
      end
      @(negedge clk);
      reset = 1'b0;
      AXIM_rvalid = 1'b0;
    end
  end

  initial begin
    repeat (NCYC + 20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
